// File: rtl/sub_arb_pkg.sv
// sub_arb_pkg: shared defaults, widths and pipeline-stage types for sub_share_arbiter.
package sub_arb_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_LAT = 3;
  localparam int ID_W = $clog2(DEF_NUM_REQ);
  typedef logic signed [DEF_DATA_W:0] sub_res_t;
  typedef struct packed {
    logic valid;
    logic [ID_W-1:0] id;
    sub_res_t res;
  } stage_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational grant from valid and a round-robin pointer.
// Defining SUB_ARB_FIXED_PRIO_EN pins the pointer at 0 (lowest index wins).
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] valid,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         hit
);
  logic [W-1:0] ptr;
  logic [W-1:0] off;
  logic [N-1:0] rot;
  logic [W:0]   sum;
`ifdef SUB_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (hit) ptr <= (idx == W'(N - 1)) ? '0 : W'(idx + 1'b1);
`endif
  // rotate so the pointer sits at bit 0, then take the lowest set bit
  always_comb begin
    rot = N'({valid, valid} >> ptr);
    off = '0;
    for (int k = N - 1; k >= 0; k--) if (rot[k]) off = W'(k);
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= (W + 1)'(N)) ? W'(sum - (W + 1)'(N)) : sum[W-1:0];
    hit = rst_n && |valid;
    grant = hit ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/sub_share_arbiter.sv
// sub_share_arbiter: shares one LAT-stage subtract pipeline between NUM_REQ requesters.
// Build option SUB_ARB_FIXED_PRIO_EN switches the arbiter to fixed lowest-index priority.
module sub_share_arbiter import sub_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LAT     = DEF_LAT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic signed [DATA_W:0]     rsp_data,
  output logic [$clog2(LAT+1)-1:0]   inflight,
  output logic                       busy
);
  localparam int CW = $clog2(LAT + 1);
  logic [ID_W-1:0] gidx;
  logic            issue;
  logic            s1_valid;
  logic [ID_W-1:0] s1_id;
  sub_res_t        s1_a;
  sub_res_t        s1_b;
  stage_t          st  [1:LAT-1];
  stage_t          nxt [1:LAT-1];
  logic            retire;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .valid(req_valid),
    .grant(req_ready),
    .idx(gidx),
    .hit(issue)
  );
  always_comb begin
    nxt[1] = '{valid: s1_valid, id: s1_id, res: s1_a - s1_b};
    for (int k = 2; k < LAT; k++) nxt[k] = st[k-1];
  end
  // the output stage keeps id/res between results so rsp_id/rsp_data hold
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_id <= '0;
      s1_a <= '0;
      s1_b <= '0;
      for (int k = 1; k < LAT; k++) st[k] <= '0;
    end else begin
      s1_valid <= issue;
      s1_id <= gidx;
      s1_a <= {1'b0, req_a[gidx*DATA_W +: DATA_W]};
      s1_b <= {1'b0, req_b[gidx*DATA_W +: DATA_W]};
      for (int k = 1; k < LAT; k++)
        if (k < LAT - 1 || nxt[k].valid) st[k] <= nxt[k];
        else st[k].valid <= 1'b0;
    end
  assign retire = st[LAT-1].valid;
  assign rsp_valid = retire ? NUM_REQ'(1) << st[LAT-1].id : '0;
  assign rsp_id = st[LAT-1].id;
  assign rsp_data = st[LAT-1].res;
  assign busy = inflight != '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) inflight <= '0;
    else if (issue && !retire) inflight <= inflight + 1'b1;
    else if (!issue && retire) inflight <= inflight - 1'b1;
  inflight_bound: assert property (@(posedge clk) disable iff (!rst_n)
    !(issue && !retire && inflight == CW'(LAT)));
endmodule

// File: tb/tb_sub_share_arbiter.sv
// tb_sub_share_arbiter: directed stimulus checked every cycle against a queue-based model.
module tb_sub_share_arbiter;
  localparam int N = 4;
  localparam int DW = 4;
  localparam int L = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*DW-1:0] req_a = '0;
  logic [N*DW-1:0] req_b = '0;
  logic [N-1:0] rsp_valid;
  logic [1:0] rsp_id;
  logic signed [DW:0] rsp_data;
  logic [1:0] inflight;
  logic busy;
  int vecs = 0;
  int errs = 0;
  typedef struct { int t; int id; int d; } op_t;
  op_t q[$];
  int ec = 0;
  int ptr = 0;
  int last_id = 0;
  int last_d = 0;
  bit rec = 0;
  int glog[$];

  sub_share_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int cur_ptr();
`ifdef SUB_ARB_FIXED_PRIO_EN
    return 0;
`else
    return ptr;
`endif
  endfunction

  function automatic int mgrant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // model: every granted op is due LAT-1 edges after its issue edge
  always @(posedge clk) begin
    int g;
    ec++;
    if (!rst_n) begin
      q.delete();
      ptr = 0;
    end else begin
      while (q.size() > 0 && q[0].t + L <= ec) void'(q.pop_front());
      g = mgrant(req_valid, cur_ptr());
      if (g >= 0) begin
        q.push_back('{t: ec, id: g, d: int'(req_a[g*DW +: DW]) - int'(req_b[g*DW +: DW])});
        ptr = (g + 1) % N;
      end
    end
  end

  always @(negedge clk) begin
    int eg;
    int cnt;
    int gi;
    logic [N-1:0] ev;
    eg = -1;
    cnt = 0;
    ev = '0;
    if (!rst_n) begin
      last_id = 0;
      last_d = 0;
    end else begin
      eg = mgrant(req_valid, cur_ptr());
      foreach (q[i]) begin
        if (q[i].t <= ec && ec < q[i].t + L) cnt++;
        if (q[i].t + L - 1 == ec) begin
          ev = N'(1) << q[i].id;
          last_id = q[i].id;
          last_d = q[i].d;
        end
      end
    end
    chk("req_ready", req_ready, eg < 0 ? 0 : 1 << eg);
    chk("rsp_valid", rsp_valid, ev);
    chk("rsp_id", rsp_id, last_id);
    chk("rsp_data", rsp_data, last_d);
    chk("inflight", inflight, cnt);
    chk("busy", busy, cnt != 0);
    if (rec) begin
      gi = -1;
      for (int k = 0; k < N; k++) if (req_ready[k]) gi = k;
      glog.push_back(gi);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int i, input int a, input int b);
    req_valid[i] = 1'b1;
    req_a[i*DW +: DW] = DW'(a);
    req_b[i*DW +: DW] = DW'(b);
  endtask

  task automatic one_op(input int i, input int a, input int b, input int exp);
    drive(i, a, b);
    step();
    req_valid = '0;
    step();
    step();
    chk("op_valid", rsp_valid, 1 << i);
    chk("op_data", rsp_data, exp);
    step();
  endtask

  initial begin
    int gexp[8];
`ifdef SUB_ARB_FIXED_PRIO_EN
    gexp = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
    gexp = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    step();
    step();
    chk("reset_inflight", inflight, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    rst_n = 1'b1;
    step();
    drive(2, 9, 3);
    @(negedge clk);
    #1;
    chk("single_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    chk("single_inflight_1", inflight, 1);
    step();
    step();
    chk("single_rsp_valid", rsp_valid, 4'b0100);
    chk("single_rsp_id", rsp_id, 2);
    chk("single_rsp_data", rsp_data, 6);
    step();
    chk("single_inflight_0", inflight, 0);
    chk("single_busy_0", busy, 0);
    chk("hold_rsp_data", rsp_data, 6);
    one_op(1, 7, 7, 0);
    one_op(0, 0, 15, -15);
    one_op(3, 15, 0, 15);
    for (int i = 0; i < N; i++) drive(i, 10 + i, 2 * i);
    rec = 1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (c == 4) chk("rr_inflight_full", inflight, 3);
    end
    req_valid = '0;
    rec = 0;
    chk("rr_grant_count", glog.size(), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++) chk("rr_grant_order", glog[i], gexp[i]);
    repeat (4) step();
    for (int i = 0; i < 5; i++) begin
      drive(1, i * 3, 14 - i);
      step();
    end
    req_valid = '0;
    repeat (4) step();
    chk("solo_drained", inflight, 0);
    drive(2, 5, 1);
    step();
    req_valid = '0;
    drive(3, 2, 9);
    step();
    req_valid = '0;
    req_valid[0] = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_data", rsp_data, 0);
    step();
    step();
    req_valid = '0;
    rst_n = 1'b1;
    repeat (5) step();
    chk("post_rst_inflight", inflight, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
